// File: rtl/slave_pkg.sv
// rtl/slave_pkg.sv - shared types and constants for the memory-backed crossbar slave
package slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic       CMD_READ  = 1'b0;
    localparam logic       CMD_WRITE = 1'b1;
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam int         COUNT_W   = 16;

endpackage

// File: rtl/lfsr8.sv
// rtl/lfsr8.sv - free-running 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1)
module lfsr8
    import slave_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] out
);

    logic [7:0] state_q;
    logic       feedback;

    assign feedback = state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3];
    assign out      = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= {state_q[6:0], feedback};
        end
    end

endmodule

// File: rtl/mem_slave.sv
// rtl/mem_slave.sv - memory-backed crossbar slave with programmable wait states
module mem_slave
    import slave_pkg::*;
#(
    parameter int N            = 32,
    parameter int DEPTH        = 16,
    parameter int ADDR_LSB     = 2,
    parameter int WAIT_CYCLES  = 2,
    parameter int STALL_RANDOM = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 slave_req,
    input  logic [N-1:0]         slave_addr,
    input  logic                 slave_cmd,
    input  logic [N-1:0]         slave_wdata,
    output logic                 slave_ack,
    output logic [N-1:0]         slave_rdata,
    output logic                 busy,
    output logic [COUNT_W-1:0]   wr_count,
    output logic [COUNT_W-1:0]   rd_count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 8;

    state_t             state, state_nx;
    logic [N-1:0]       mem [DEPTH];
    logic [IDX_W-1:0]   idx_q;
    logic               cmd_q;
    logic [N-1:0]       wdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   wait_total;
    logic [7:0]         lfsr_val;
    logic               unused_bits;

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .out (lfsr_val)
    );

    // Only the word-index field of the address and two LFSR bits matter.
    assign unused_bits = ^{slave_addr, lfsr_val};

    assign wait_total = CNT_W'(WAIT_CYCLES)
                      + ((STALL_RANDOM != 0) ? {{(CNT_W-2){1'b0}}, lfsr_val[1:0]}
                                             : {CNT_W{1'b0}});

    assign slave_ack = (state == ACK);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (slave_req) begin
                    state_nx = (wait_total == '0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                // Abandonment wins over a counter that is about to expire.
                if (!slave_req) begin
                    state_nx = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_nx = ACK;
                end
            end
            ACK:     state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx_q       <= '0;
            cmd_q       <= CMD_READ;
            wdata_q     <= '0;
            cnt_q       <= '0;
            slave_rdata <= '0;
            wr_count    <= '0;
            rd_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (slave_req) begin
                        idx_q   <= slave_addr[ADDR_LSB +: IDX_W];
                        cmd_q   <= slave_cmd;
                        wdata_q <= slave_wdata;
                        cnt_q   <= wait_total;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                ACK: begin
                    if (cmd_q == CMD_WRITE) begin
                        mem[idx_q] <= wdata_q;
                        if (wr_count != '1) begin
                            wr_count <= wr_count + COUNT_W'(1);
                        end
                    end else begin
                        slave_rdata <= mem[idx_q];
                        if (rd_count != '1) begin
                            rd_count <= rd_count + COUNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_slave.sv
// tb/tb_mem_slave.sv - self-checking bench for mem_slave across three parameter sets
module tb_mem_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        cmd   [3];
    logic [31:0] wdata [3];
    logic        ack   [3];
    logic [31:0] rdata [3];
    logic        busy  [3];
    logic [15:0] wrc   [3];
    logic [15:0] rdc   [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          lat_q [$];
    logic [31:0] dat_q [$];
    logic [7:0]  m_lfsr;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    mem_slave #(.WAIT_CYCLES(2), .STALL_RANDOM(0)) u_w2 (
        .clk(clk), .rst(rst), .slave_req(req[0]), .slave_addr(addr[0]), .slave_cmd(cmd[0]),
        .slave_wdata(wdata[0]), .slave_ack(ack[0]), .slave_rdata(rdata[0]), .busy(busy[0]),
        .wr_count(wrc[0]), .rd_count(rdc[0]));

    mem_slave #(.WAIT_CYCLES(0), .STALL_RANDOM(0)) u_w0 (
        .clk(clk), .rst(rst), .slave_req(req[1]), .slave_addr(addr[1]), .slave_cmd(cmd[1]),
        .slave_wdata(wdata[1]), .slave_ack(ack[1]), .slave_rdata(rdata[1]), .busy(busy[1]),
        .wr_count(wrc[1]), .rd_count(rdc[1]));

    mem_slave #(.WAIT_CYCLES(2), .STALL_RANDOM(1)) u_rnd (
        .clk(clk), .rst(rst), .slave_req(req[2]), .slave_addr(addr[2]), .slave_cmd(cmd[2]),
        .slave_wdata(wdata[2]), .slave_ack(ack[2]), .slave_rdata(rdata[2]), .busy(busy[2]),
        .wr_count(wrc[2]), .rd_count(rdc[2]));

    // Issued at a negedge with the slave idle; returns at a negedge with the slave idle again.
    task automatic do_txn(input int d, input logic c, input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output int ack_cyc);
        bit done;
        req[d] = 1'b1; cmd[d] = c; addr[d] = a; wdata[d] = wd;
        lat = -1; ack_cyc = -1; done = 0;
        for (int k = 1; k <= 20; k++) begin
            if (!done) begin
                @(negedge clk);
                if (ack[d]) begin
                    lat = k; ack_cyc = cyc; done = 1;
                end
            end
        end
        req[d] = 1'b0;
        @(negedge clk);
        rd = rdata[d];
        @(negedge clk);
    endtask

    task automatic test_reset();
        bit seen;
        seen = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) if (ack[d]) seen = 1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL reset_idle_ack got=%0b want=0", seen); end
        for (int d = 0; d < 3; d++) begin
            total++; if (rdata[d] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d] got=%h want=0", d, rdata[d]); end
            total++; if (busy[d] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b want=0", d, busy[d]); end
            total++; if (wrc[d] !== 16'd0 || rdc[d] !== 16'd0) begin
                bad++; $display("FAIL reset_counts[%0d] got=%0d/%0d want=0/0", d, wrc[d], rdc[d]);
            end
        end
    endtask

    task automatic test_wait2();
        int lat, ac, e;
        logic [31:0] rd, ed;
        lat_q.push_back(3);
        do_txn(0, 1'b1, 32'h8, 32'hAAAAAAAA, lat, rd, ac);
        e = lat_q.pop_front();
        total++; if (lat !== e) begin bad++; $display("FAIL w2_write_lat got=%0d want=%0d", lat, e); end
        lat_q.push_back(3);
        dat_q.push_back(32'hAAAAAAAA);
        do_txn(0, 1'b0, 32'h8, 32'h0, lat, rd, ac);
        e = lat_q.pop_front(); ed = dat_q.pop_front();
        total++; if (lat !== e) begin bad++; $display("FAIL w2_read_lat got=%0d want=%0d", lat, e); end
        total++; if (rd !== ed) begin bad++; $display("FAIL w2_read_data got=%h want=%h", rd, ed); end
        total++; if (wrc[0] !== 16'd1 || rdc[0] !== 16'd1) begin
            bad++; $display("FAIL w2_counts got=%0d/%0d want=1/1", wrc[0], rdc[0]);
        end
    endtask

    task automatic test_wait0_alias();
        int lat, c1, c2, e;
        logic [31:0] rd, ed;
        lat_q.push_back(1);
        do_txn(1, 1'b1, 32'h4, 32'hBBBBBBBB, lat, rd, c1);
        e = lat_q.pop_front();
        total++; if (lat !== e) begin bad++; $display("FAIL w0_write_lat got=%0d want=%0d", lat, e); end
        lat_q.push_back(1);
        dat_q.push_back(32'hBBBBBBBB);
        do_txn(1, 1'b0, 32'h44, 32'h0, lat, rd, c2);
        e = lat_q.pop_front(); ed = dat_q.pop_front();
        total++; if (lat !== e) begin bad++; $display("FAIL w0_read_lat got=%0d want=%0d", lat, e); end
        total++; if (rd !== ed) begin bad++; $display("FAIL w0_alias_data got=%h want=%h", rd, ed); end
        total++; if (c2 - c1 !== 3) begin bad++; $display("FAIL w0_issue_period got=%0d want=3", c2 - c1); end
    endtask

    task automatic test_drop();
        bit seen;
        int lat, ac;
        logic [31:0] rd, ed;
        seen = 0;
        req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 32'h0; wdata[0] = 32'h11111111;
        @(negedge clk);
        req[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack[0]) seen = 1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL drop_ack got=%0b want=0", seen); end
        total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL drop_busy got=%b want=0", busy[0]); end
        dat_q.push_back(32'h0);
        do_txn(0, 1'b0, 32'h0, 32'h0, lat, rd, ac);
        ed = dat_q.pop_front();
        total++; if (rd !== ed) begin bad++; $display("FAIL drop_mem got=%h want=%h", rd, ed); end
        total++; if (wrc[0] !== 16'd1) begin bad++; $display("FAIL drop_wr_count got=%0d want=1", wrc[0]); end
    endtask

    task automatic test_rst_mid();
        int lat, ac;
        logic [31:0] rd, ed;
        dat_q.push_back(32'hAAAAAAAA);
        do_txn(0, 1'b0, 32'h8, 32'h0, lat, rd, ac);
        ed = dat_q.pop_front();
        total++; if (rd !== ed) begin bad++; $display("FAIL rstmid_pre_data got=%h want=%h", rd, ed); end
        req[0] = 1'b1; cmd[0] = 1'b1; addr[0] = 32'h0; wdata[0] = 32'h22222222;
        @(negedge clk);
        rst = 1'b1;
        req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        total++; if (ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
            bad++; $display("FAIL rstmid_ack_busy got=%b/%b want=0/0", ack[0], busy[0]);
        end
        total++; if (rdata[0] !== 32'h0) begin bad++; $display("FAIL rstmid_rdata got=%h want=0", rdata[0]); end
        total++; if (wrc[0] !== 16'd0 || rdc[0] !== 16'd0) begin
            bad++; $display("FAIL rstmid_counts got=%0d/%0d want=0/0", wrc[0], rdc[0]);
        end
        @(negedge clk);
        dat_q.push_back(32'h0);
        do_txn(0, 1'b0, 32'h0, 32'h0, lat, rd, ac);
        ed = dat_q.pop_front();
        total++; if (rd !== ed) begin bad++; $display("FAIL rstmid_mem0 got=%h want=%h", rd, ed); end
        dat_q.push_back(32'h0);
        do_txn(0, 1'b0, 32'h8, 32'h0, lat, rd, ac);
        ed = dat_q.pop_front();
        total++; if (rd !== ed) begin bad++; $display("FAIL rstmid_mem8 got=%h want=%h", rd, ed); end
    endtask

    task automatic test_random_stall();
        int lat, ac, e;
        logic [31:0] rd, ed;
        for (int i = 0; i < 64; i++) begin
            lat_q.push_back(3 + int'(m_lfsr[1:0]));
            dat_q.push_back(32'h0);
            do_txn(2, 1'b0, 32'(i * 4), 32'h0, lat, rd, ac);
            e = lat_q.pop_front(); ed = dat_q.pop_front();
            total++; if (lat !== e) begin bad++; $display("FAIL rnd_lat[%0d] got=%0d want=%0d", i, lat, e); end
            total++; if (lat < 3 || lat > 6) begin bad++; $display("FAIL rnd_range[%0d] got=%0d want=3..6", i, lat); end
            total++; if (rd !== ed) begin bad++; $display("FAIL rnd_data[%0d] got=%h want=%h", i, rd, ed); end
        end
        total++; if (rdc[2] !== 16'd64) begin bad++; $display("FAIL rnd_rd_count got=%0d want=64", rdc[2]); end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            req[d] = 1'b0; cmd[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0;
        end
        test_reset();
        test_wait2();
        test_wait0_alias();
        test_drop();
        test_rst_mid();
        test_random_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
